descriptor_table_walker: RTL and testbench

DESCRIPTOR_TABLE_WALKER -- requirements
Module: descriptor_table_walker

---
 rtl/descriptor_table_walker.sv | 195 +++++++++++++++++++
 tb/tb_descriptor_table_walker.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/descriptor_table_walker.sv
// Descriptor table walker: bounds-checks an index against the table limit, then fetches a 64-bit
// descriptor as two 32-bit reads. Optional one-entry cache: define DESCRIPTOR_TABLE_CACHE_EN.
module descriptor_table_walker #(
   parameter int BASE_WIDTH  = 32,
   parameter int LIMIT_WIDTH = 16,
   parameter int INDEX_WIDTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   table_write_enable,
   input  logic [LIMIT_WIDTH-1:0] table_write_limit,
   input  logic [BASE_WIDTH-1:0]  table_write_base,
   output logic [LIMIT_WIDTH-1:0] table_limit,
   output logic [BASE_WIDTH-1:0]  table_base,
   input  logic                   lookup_valid,
   output logic                   lookup_ready,
   input  logic [INDEX_WIDTH-1:0] lookup_index,
   output logic                   mem_read_valid,
   input  logic                   mem_read_ready,
   output logic [BASE_WIDTH-1:0]  mem_read_address,
   input  logic                   mem_read_data_valid,
   input  logic [31:0]            mem_read_data,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic [63:0]            result_descriptor,
   output logic                   result_fault
);
   localparam int EW = LIMIT_WIDTH + INDEX_WIDTH + 3;

   typedef enum logic [2:0] {IDLE, CHECK, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, RESP} state_t;

   state_t                 state_q, state_d;
   logic [BASE_WIDTH-1:0]  base_q, base_d, sbase_q, sbase_d, addr_q, addr_d;
   logic [LIMIT_WIDTH-1:0] limit_q, limit_d, slimit_q, slimit_d;
   logic [INDEX_WIDTH-1:0] idx_q, idx_d;
   logic [31:0]            lo_q, lo_d;
   logic [63:0]            desc_q, desc_d;
   logic                   fault_q, fault_d;
   logic [EW-1:0]          end_w;
   logic                   over_w;
   logic                   hit_w;
   logic [63:0]            hit_desc_w;

   // Last byte of the descriptor; wide enough that index*8+7 never wraps.
   assign end_w  = {{LIMIT_WIDTH{1'b0}}, idx_q, 3'b111};
   assign over_w = end_w > EW'(slimit_q);

   assign table_base  = base_q;
   assign table_limit = limit_q;

`ifdef DESCRIPTOR_TABLE_CACHE_EN
   logic                   cvld_q, cvld_d;
   logic [INDEX_WIDTH-1:0] cidx_q, cidx_d;
   logic [63:0]            cdesc_q, cdesc_d;

   assign hit_w      = cvld_q && (cidx_q == idx_q);
   assign hit_desc_w = cdesc_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cvld_q  <= 1'b0;
         cidx_q  <= '0;
         cdesc_q <= '0;
      end else begin
         cvld_q  <= cvld_d;
         cidx_q  <= cidx_d;
         cdesc_q <= cdesc_d;
      end
   end
`else
   assign hit_w      = 1'b0;
   assign hit_desc_w = '0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         base_q   <= '0;
         limit_q  <= '0;
         sbase_q  <= '0;
         slimit_q <= '0;
         idx_q    <= '0;
         addr_q   <= '0;
         lo_q     <= '0;
         desc_q   <= '0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         limit_q  <= limit_d;
         sbase_q  <= sbase_d;
         slimit_q <= slimit_d;
         idx_q    <= idx_d;
         addr_q   <= addr_d;
         lo_q     <= lo_d;
         desc_q   <= desc_d;
         fault_q  <= fault_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      limit_d  = limit_q;
      sbase_d  = sbase_q;
      slimit_d = slimit_q;
      idx_d    = idx_q;
      addr_d   = addr_q;
      lo_d     = lo_q;
      desc_d   = desc_q;
      fault_d  = fault_q;
`ifdef DESCRIPTOR_TABLE_CACHE_EN
      cvld_d   = cvld_q;
      cidx_d   = cidx_q;
      cdesc_d  = cdesc_q;
`endif
      lookup_ready      = 1'b0;
      mem_read_valid    = 1'b0;
      mem_read_address  = '0;
      result_valid      = 1'b0;
      result_descriptor = '0;
      result_fault      = 1'b0;

      if (table_write_enable) begin
         base_d  = table_write_base;
         limit_d = table_write_limit;
      end

      case (state_q)
         IDLE: begin
            lookup_ready = 1'b1;
            if (lookup_valid) begin
               // Snapshot the pre-write table so a concurrent write cannot disturb this walk.
               idx_d    = lookup_index;
               sbase_d  = base_q;
               slimit_d = limit_q;
               state_d  = CHECK;
            end
         end
         CHECK: begin
            addr_d = sbase_q + BASE_WIDTH'({idx_q, 3'b000});
            if (over_w) begin
               fault_d = 1'b1;
               desc_d  = '0;
               state_d = RESP;
            end else if (hit_w) begin
               fault_d = 1'b0;
               desc_d  = hit_desc_w;
               state_d = RESP;
            end else begin
               fault_d = 1'b0;
               state_d = REQ_LO;
            end
         end
         REQ_LO: begin
            mem_read_valid   = 1'b1;
            mem_read_address = addr_q;
            if (mem_read_ready) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (mem_read_data_valid) begin
               lo_d    = mem_read_data;
               state_d = REQ_HI;
            end
         end
         REQ_HI: begin
            mem_read_valid   = 1'b1;
            mem_read_address = addr_q + BASE_WIDTH'(4);
            if (mem_read_ready) state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (mem_read_data_valid) begin
               desc_d  = {mem_read_data, lo_q};
               state_d = RESP;
`ifdef DESCRIPTOR_TABLE_CACHE_EN
               cvld_d  = 1'b1;
               cidx_d  = idx_q;
               cdesc_d = {mem_read_data, lo_q};
`endif
            end
         end
         RESP: begin
            result_valid      = 1'b1;
            result_descriptor = desc_q;
            result_fault      = fault_q;
            if (result_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

`ifdef DESCRIPTOR_TABLE_CACHE_EN
      if (table_write_enable) cvld_d = 1'b0;
`endif
   end
endmodule

// File: tb/tb_descriptor_table_walker.sv
// Scoreboard bench for descriptor_table_walker: memory model returns addr ^ 0xDEAD0000,
// expected addresses and results are queued by the stimulus and popped by the model/monitor.
module tb_descriptor_table_walker;
   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        table_write_enable = 1'b0;
   logic [15:0] table_write_limit = '0;
   logic [31:0] table_write_base = '0;
   logic [15:0] table_limit;
   logic [31:0] table_base;
   logic        lookup_valid = 1'b0;
   logic        lookup_ready;
   logic [7:0]  lookup_index = '0;
   logic        mem_read_valid;
   logic        mem_read_ready;
   logic [31:0] mem_read_address;
   logic        mem_read_data_valid;
   logic [31:0] mem_read_data;
   logic        result_valid;
   logic        result_ready;
   logic [63:0] result_descriptor;
   logic        result_fault;

   descriptor_table_walker dut (
      .clock(clock), .reset(reset),
      .table_write_enable(table_write_enable), .table_write_limit(table_write_limit),
      .table_write_base(table_write_base), .table_limit(table_limit), .table_base(table_base),
      .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_index(lookup_index),
      .mem_read_valid(mem_read_valid), .mem_read_ready(mem_read_ready),
      .mem_read_address(mem_read_address), .mem_read_data_valid(mem_read_data_valid),
      .mem_read_data(mem_read_data), .result_valid(result_valid), .result_ready(result_ready),
      .result_descriptor(result_descriptor), .result_fault(result_fault)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [63:0] desc;
      logic        fault;
   } res_t;

   res_t        exp_q[$];
   logic [31:0] exp_addr_q[$];

   int total = 0, bad = 0;
   int cyc = 0;
   int mem_stall = 0, res_stall = 0;
   bit drop_hi = 1'b0;
   int stray_req = 0;
   int hs_cnt = 0, stray_done = 0, res_first_cyc = 0, res_cnt = 0;
   int accept_cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory model: optional stall before ready, data one cycle after the handshake.
   initial begin
      bit          in_req = 1'b0, pend = 1'b0, pend_hi = 1'b0, hi_ph = 1'b0;
      int          st = 0;
      logic [31:0] held = '0, pdata = '0;
      mem_read_ready = 1'b0;
      mem_read_data_valid = 1'b0;
      mem_read_data = '0;
      forever begin
         @(negedge clock);
         mem_read_data_valid = 1'b0;
         mem_read_ready = 1'b0;
         if (!reset) begin
            in_req = 1'b0; pend = 1'b0; hi_ph = 1'b0;
         end else begin
            if (pend) begin
               pend = 1'b0;
               if (!(drop_hi && pend_hi)) begin
                  mem_read_data_valid = 1'b1;
                  mem_read_data = pdata;
               end
            end else if (stray_req != stray_done) begin
               mem_read_data_valid = 1'b1;
               mem_read_data = 32'hBAD0_BAD0;
               stray_done++;
            end
            if (mem_read_valid) begin
               if (!in_req) begin
                  in_req = 1'b1;
                  st = mem_stall;
                  held = mem_read_address;
                  if (exp_addr_q.size() == 0) begin
                     total++; bad++;
                     $display("FAIL unexpected_read: got addr %h, none expected", mem_read_address);
                  end else chk("read_addr", 64'(mem_read_address), 64'(exp_addr_q.pop_front()));
               end else chk("addr_stable", 64'(mem_read_address), 64'(held));
               chk("lookup_ready_busy", 64'(lookup_ready), 64'd0);
               if (st > 0) st--;
               else begin
                  mem_read_ready = 1'b1;
                  in_req = 1'b0;
                  hs_cnt++;
                  pend = 1'b1;
                  pend_hi = hi_ph;
                  hi_ph = !hi_ph;
                  pdata = held ^ 32'hDEAD_0000;
               end
            end
         end
      end
   end

   // Result monitor: optional back-pressure, stability check while held, scoreboard compare.
   initial begin
      bit          seen = 1'b0;
      int          hold = 0;
      logic [63:0] hd = '0;
      logic        hf = 1'b0;
      res_t        e;
      result_ready = 1'b0;
      forever begin
         @(negedge clock);
         result_ready = 1'b0;
         if (reset && result_valid) begin
            if (!seen) begin
               seen = 1'b1; hold = res_stall; hd = result_descriptor; hf = result_fault;
               res_first_cyc = cyc;
            end else begin
               chk("res_desc_stable", result_descriptor, hd);
               chk("res_fault_stable", 64'(result_fault), 64'(hf));
               chk("lookup_ready_resp", 64'(lookup_ready), 64'd0);
            end
            if (hold > 0) hold--;
            else begin
               result_ready = 1'b1;
               seen = 1'b0;
               res_cnt++;
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_result: got %h fault %0d, none expected",
                           result_descriptor, result_fault);
               end else begin
                  e = exp_q.pop_front();
                  chk("res_desc", result_descriptor, e.desc);
                  chk("res_fault", 64'(result_fault), 64'(e.fault));
               end
            end
         end else if (reset && seen) begin
            chk("res_valid_held", 64'(result_valid), 64'd1);
            seen = 1'b0;
         end
      end
   end

   task automatic twrite(input logic [31:0] b, input logic [15:0] l);
      @(negedge clock);
      table_write_enable = 1'b1; table_write_base = b; table_write_limit = l;
      @(negedge clock);
      table_write_enable = 1'b0;
   endtask

   task automatic lookup(input logic [7:0] idx);
      int t = 0;
      @(negedge clock);
      while (!lookup_ready && t < 500) begin @(negedge clock); t++; end
      if (t >= 500) begin total++; bad++; $display("FAIL lookup_ready_timeout: got 0 expected 1"); end
      lookup_valid = 1'b1; lookup_index = idx;
      @(negedge clock);
      lookup_valid = 1'b0;
      accept_cyc = cyc;
   endtask

   task automatic wait_done();
      int t = 0;
      while ((exp_q.size() != 0 || !lookup_ready) && t < 500) begin @(negedge clock); t++; end
      if (t >= 500) begin
         total++; bad++;
         $display("FAIL done_timeout: got %0d pending results expected 0", exp_q.size());
      end
   endtask

   task automatic push_res(input logic [63:0] d, input logic f);
      res_t r;
      r.desc = d; r.fault = f;
      exp_q.push_back(r);
   endtask

   initial begin
      int h0, r0, t;
      repeat (3) @(negedge clock);
      chk("rst_base", 64'(table_base), 64'd0);
      chk("rst_limit", 64'(table_limit), 64'd0);
      chk("rst_mem_valid", 64'(mem_read_valid), 64'd0);
      chk("rst_res_valid", 64'(result_valid), 64'd0);
      chk("rst_res_desc", result_descriptor, 64'd0);
      chk("rst_res_fault", 64'(result_fault), 64'd0);
      reset = 1'b1;
      @(negedge clock);
      chk("idle_ready", 64'(lookup_ready), 64'd1);

      // Basic fetch
      twrite(32'h0001_0000, 16'h07FF);
      chk("wr_base", 64'(table_base), 64'h0001_0000);
      chk("wr_limit", 64'(table_limit), 64'h07FF);
      h0 = hs_cnt;
      exp_addr_q.push_back(32'h0001_0080); exp_addr_q.push_back(32'h0001_0084);
      push_res(64'hDEAC0084_DEAC0080, 1'b0);
      lookup(8'h10); wait_done();
      chk("fetch_reads", 64'(hs_cnt - h0), 64'd2);

      // Limit boundary: last fitting descriptor, then first faulting one
      twrite(32'h0001_0000, 16'h007F);
      exp_addr_q.push_back(32'h0001_0078); exp_addr_q.push_back(32'h0001_007C);
      push_res(64'hDEAC007C_DEAC0078, 1'b0);
      lookup(8'h0F); wait_done();
      h0 = hs_cnt;
      push_res(64'd0, 1'b1);
      lookup(8'h10); wait_done();
      chk("fault_no_reads", 64'(hs_cnt - h0), 64'd0);
      // accept edge -> CHECK, next edge -> RESP
      chk("fault_latency", 64'(res_first_cyc - accept_cyc), 64'd1);

      // Address wrap across 2^32
      twrite(32'hFFFF_FFFC, 16'h07FF);
      exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0000_0000);
      push_res(64'hDEAD0000_2152FFFC, 1'b0);
      lookup(8'h00); wait_done();

      // Back-pressure on both sides, plus a table write while in flight
      twrite(32'h0001_0000, 16'h07FF);
      mem_stall = 5; res_stall = 3;
      exp_addr_q.push_back(32'h0001_0010); exp_addr_q.push_back(32'h0001_0014);
      push_res(64'hDEAC0014_DEAC0010, 1'b0);
      lookup(8'h02);
      twrite(32'h0002_0000, 16'h07FF);
      wait_done();
      chk("inflight_write_base", 64'(table_base), 64'h0002_0000);
      mem_stall = 0; res_stall = 0;

      // Repeat lookup: served from cache when present, cache dropped by a table write
      twrite(32'h0001_0000, 16'h07FF);
      exp_addr_q.push_back(32'h0001_0080); exp_addr_q.push_back(32'h0001_0084);
      push_res(64'hDEAC0084_DEAC0080, 1'b0);
      lookup(8'h10); wait_done();
      h0 = hs_cnt;
`ifndef DESCRIPTOR_TABLE_CACHE_EN
      exp_addr_q.push_back(32'h0001_0080); exp_addr_q.push_back(32'h0001_0084);
`endif
      push_res(64'hDEAC0084_DEAC0080, 1'b0);
      lookup(8'h10); wait_done();
`ifdef DESCRIPTOR_TABLE_CACHE_EN
      chk("repeat_reads", 64'(hs_cnt - h0), 64'd0);
      chk("hit_latency", 64'(res_first_cyc - accept_cyc), 64'd1);
`else
      chk("repeat_reads", 64'(hs_cnt - h0), 64'd2);
`endif
      twrite(32'h0001_0000, 16'h07FF);
      h0 = hs_cnt;
      exp_addr_q.push_back(32'h0001_0080); exp_addr_q.push_back(32'h0001_0084);
      push_res(64'hDEAC0084_DEAC0080, 1'b0);
      lookup(8'h10); wait_done();
      chk("after_write_reads", 64'(hs_cnt - h0), 64'd2);

      // Reset while waiting for the high word; a late data beat must be ignored
      drop_hi = 1'b1;
      h0 = hs_cnt; r0 = res_cnt;
      exp_addr_q.push_back(32'h0001_0018); exp_addr_q.push_back(32'h0001_001C);
      lookup(8'h03);
      t = 0;
      while (hs_cnt < h0 + 2 && t < 200) begin @(negedge clock); t++; end
      if (t >= 200) begin total++; bad++; $display("FAIL hi_read_timeout: got %0d reads expected 2", hs_cnt - h0); end
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("mid_rst_res_valid", 64'(result_valid), 64'd0);
      chk("mid_rst_res_desc", result_descriptor, 64'd0);
      chk("mid_rst_res_fault", 64'(result_fault), 64'd0);
      chk("mid_rst_mem_valid", 64'(mem_read_valid), 64'd0);
      chk("mid_rst_base", 64'(table_base), 64'd0);
      chk("mid_rst_limit", 64'(table_limit), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      drop_hi = 1'b0;
      stray_req++;
      repeat (6) @(negedge clock);
      chk("post_rst_idle", 64'(lookup_ready), 64'd1);
      chk("post_rst_no_result", 64'(res_cnt - r0), 64'd0);
      chk("post_rst_res_valid", 64'(result_valid), 64'd0);

      // Cleared table (limit 0): index 0 spans bytes 0..7, so it faults
      h0 = hs_cnt;
      push_res(64'd0, 1'b1);
      lookup(8'h00); wait_done();
      chk("zero_limit_no_reads", 64'(hs_cnt - h0), 64'd0);

      repeat (3) @(negedge clock);
      chk("results_left", 64'(exp_q.size()), 64'd0);
      chk("reads_left", 64'(exp_addr_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
